// File: rtl/stopwatch_timer_core_if.sv
// stopwatch_timer_core_if: button/switch inputs and display/status outputs
// of the stopwatch core, bundled with master (board/driver) and slave
// (core) views.
interface stopwatch_timer_core_if;
  logic        en;
  logic        dir_pulse;
  logic        inc_pulse;
  logic        enter_pulse;
  logic [3:0]  DIGIT;
  logic [6:0]  DISPLAY;
  logic        dir_led;
  logic        done;
  logic [15:0] time_bcd;

  modport master (
    output en, dir_pulse, inc_pulse, enter_pulse,
    input  DIGIT, DISPLAY, dir_led, done, time_bcd
  );

  modport slave (
    input  en, dir_pulse, inc_pulse, enter_pulse,
    output DIGIT, DISPLAY, dir_led, done, time_bcd
  );
endinterface

// File: rtl/stopwatch_timer_core.sv
// stopwatch_timer_core: count-up/count-down stopwatch with digit-by-digit
// entry, run/pause, done flag and a scanned 4-digit 7-segment display.
// Optional macro EDIT_BLINK_EN: blank the digit under edit on alternate
// BLINK_DIV-cycle half-periods while in the SET states.
module stopwatch_timer_core #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int SCAN_DIV  = 1024,
  parameter int MAX_MIN   = 1,
  parameter int BLINK_DIV = 25_000_000
) (
  input logic                   clk,
  input logic                   rst,
  stopwatch_timer_core_if.slave bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0]    MIN_TOP   = 4'(MAX_MIN);
  localparam logic [6:0]    SEG_DASH  = 7'b0111111;

  typedef enum logic [2:0] {S_DIR, S_MIN, S_TEN, S_SEC, S_TENTH, S_RUN} state_t;

  state_t         state, state_next;
  logic [3:0]     t_min, t_ten, t_sec, t_tth;
  logic [3:0]     t_min_next, t_ten_next, t_sec_next, t_tth_next;
  logic [15:0]    goal, goal_next;
  logic           dir_led, dir_led_next;
  logic [TW-1:0]  tick_cnt, tick_cnt_next;
  logic           step;
  logic [15:0]    cur;
  logic           done;
  logic           at_top, at_zero;
  logic [SW-1:0]  scan_cnt;
  logic [1:0]     slot, slot_next;
  logic [3:0]     digit;
  logic [6:0]     display, seg_next;
  logic [3:0]     shown;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign cur     = {t_min, t_ten, t_sec, t_tth};
  // done is only meaningful once running; the SET states may pass through goal.
  assign done    = (state == S_RUN) && (cur == goal);
  assign at_top  = (t_min == MIN_TOP) && (t_ten == 4'd5) && (t_sec == 4'd9) && (t_tth == 4'd9);
  assign at_zero = (cur == 16'h0000);

  assign bus.DIGIT    = digit;
  assign bus.DISPLAY  = display;
  assign bus.dir_led  = dir_led;
  assign bus.done     = done;
  assign bus.time_bcd = cur;

  // Control state, entered time, goal, direction and tick phase registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_DIR;
      t_min    <= '0;
      t_ten    <= '0;
      t_sec    <= '0;
      t_tth    <= '0;
      goal     <= '0;
      dir_led  <= 1'b0;
      tick_cnt <= '0;
    end else begin
      state    <= state_next;
      t_min    <= t_min_next;
      t_ten    <= t_ten_next;
      t_sec    <= t_sec_next;
      t_tth    <= t_tth_next;
      goal     <= goal_next;
      dir_led  <= dir_led_next;
      tick_cnt <= tick_cnt_next;
    end
  end

  // Next state: entry editing, RUN hand-off and one-tenth stepping toward goal.
  always_comb begin
    state_next    = state;
    t_min_next    = t_min;
    t_ten_next    = t_ten;
    t_sec_next    = t_sec;
    t_tth_next    = t_tth;
    goal_next     = goal;
    dir_led_next  = dir_led;
    tick_cnt_next = tick_cnt;
    step          = 1'b0;
    case (state)
      S_DIR: begin
        if (bus.enter_pulse) begin
          state_next = S_MIN;
          t_min_next = '0;
          t_ten_next = '0;
          t_sec_next = '0;
          t_tth_next = '0;
        end else if (bus.dir_pulse) begin
          dir_led_next = ~dir_led;
        end
      end
      S_MIN: begin
        if (bus.enter_pulse)    state_next = S_TEN;
        else if (bus.inc_pulse) t_min_next = (t_min >= MIN_TOP) ? 4'd0 : t_min + 4'd1;
      end
      S_TEN: begin
        if (bus.enter_pulse)    state_next = S_SEC;
        else if (bus.inc_pulse) t_ten_next = (t_ten >= 4'd5) ? 4'd0 : t_ten + 4'd1;
      end
      S_SEC: begin
        if (bus.enter_pulse)    state_next = S_TENTH;
        else if (bus.inc_pulse) t_sec_next = (t_sec >= 4'd9) ? 4'd0 : t_sec + 4'd1;
      end
      S_TENTH: begin
        if (bus.enter_pulse) begin
          state_next    = S_RUN;
          tick_cnt_next = '0;
          if (dir_led) begin
            goal_next = '0;
          end else begin
            // Count-up: the entered value becomes the target, counting from zero.
            goal_next  = cur;
            t_min_next = '0;
            t_ten_next = '0;
            t_sec_next = '0;
            t_tth_next = '0;
          end
        end else if (bus.inc_pulse) begin
          t_tth_next = (t_tth >= 4'd9) ? 4'd0 : t_tth + 4'd1;
        end
      end
      S_RUN: begin
        if (bus.en) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_next = '0;
            step          = ~done;
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
        if (step && dir_led && !at_zero) begin
          if (t_tth != 4'd0) t_tth_next = t_tth - 4'd1;
          else begin
            t_tth_next = 4'd9;
            if (t_sec != 4'd0) t_sec_next = t_sec - 4'd1;
            else begin
              t_sec_next = 4'd9;
              if (t_ten != 4'd0) t_ten_next = t_ten - 4'd1;
              else begin
                t_ten_next = 4'd5;
                t_min_next = t_min - 4'd1;
              end
            end
          end
        end else if (step && !dir_led && !at_top) begin
          if (t_tth != 4'd9) t_tth_next = t_tth + 4'd1;
          else begin
            t_tth_next = 4'd0;
            if (t_sec != 4'd9) t_sec_next = t_sec + 4'd1;
            else begin
              t_sec_next = 4'd0;
              if (t_ten != 4'd5) t_ten_next = t_ten + 4'd1;
              else begin
                t_ten_next = 4'd0;
                t_min_next = t_min + 4'd1;
              end
            end
          end
        end
      end
      default: state_next = S_DIR;
    endcase
  end

`ifdef EDIT_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    SEG_BLANK  = 7'b1111111;
  logic [BW-1:0] blink_cnt;
  logic          blink_off;

  // Blink half-period timer; restarts visible whenever a new field is selected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (bus.enter_pulse) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`else
  localparam int unused_blink_div = BLINK_DIV;
`endif

  // Segment pattern for the slot that will be selected after this edge.
  always_comb begin
    slot_next = (scan_cnt == SCAN_LAST) ? slot + 2'd1 : slot;
    case (slot_next)
      2'd0:    shown = t_tth;
      2'd1:    shown = t_sec;
      2'd2:    shown = t_ten;
      default: shown = t_min;
    endcase
    seg_next = (state == S_DIR) ? SEG_DASH : seg7(shown);
`ifdef EDIT_BLINK_EN
    if (blink_off &&
        ((state == S_MIN   && slot_next == 2'd3) ||
         (state == S_TEN   && slot_next == 2'd2) ||
         (state == S_SEC   && slot_next == 2'd1) ||
         (state == S_TENTH && slot_next == 2'd0)))
      seg_next = SEG_BLANK;
`endif
  end

  // Digit scan; DIGIT and DISPLAY are registered together so they never skew.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      slot     <= 2'd0;
      digit    <= 4'b1110;
      display  <= SEG_DASH;
    end else begin
      scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
      slot     <= slot_next;
      digit    <= ~(4'b0001 << slot_next);
      display  <= seg_next;
    end
  end

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// tb_stopwatch_timer_core: randomized and directed checks of the stopwatch
// core against a tenths-of-a-second integer model of the stopwatch rules.
`timescale 1ns/1ps
module tb_stopwatch_timer_core;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int MAX_MIN  = 1;
  localparam logic [6:0] DASH = 7'b0111111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  stopwatch_timer_core_if bus();

  stopwatch_timer_core #(
    .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .MAX_MIN(MAX_MIN), .BLINK_DIV(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model: 0 = DIR, 1..4 = SET min/tens/sec/tenth, 5 = RUN; time in tenths.
  int m_state, m_t, m_goal, m_encnt, m_cyc;
  bit m_dir;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [3:0] dig_tab [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic logic [15:0] to_bcd(int t);
    return {4'(t / 600), 4'((t % 600) / 100), 4'((t % 100) / 10), 4'(t % 10)};
  endfunction

  function automatic int digit_at(int t, int s);
    case (s)
      0:       return t % 10;
      1:       return (t % 100) / 10;
      2:       return (t % 600) / 100;
      default: return t / 600;
    endcase
  endfunction

  function automatic bit m_done();
    return (m_state == 5) && (m_t == m_goal);
  endfunction

  task automatic model_step(input bit e, input bit d, input bit i, input bit n);
    int mi, te, se, th;
    mi = m_t / 600; te = (m_t % 600) / 100; se = (m_t % 100) / 10; th = m_t % 10;
    if (m_state == 0) begin
      if (n) begin m_state = 1; m_t = 0; end
      else if (d) m_dir = !m_dir;
    end else if (m_state <= 4) begin
      if (n) begin
        if (m_state == 4) begin
          m_state = 5; m_encnt = 0;
          if (m_dir) m_goal = 0;
          else begin m_goal = m_t; m_t = 0; end
        end else m_state++;
      end else if (i) begin
        case (m_state)
          1:       mi = (mi + 1) % (MAX_MIN + 1);
          2:       te = (te + 1) % 6;
          3:       se = (se + 1) % 10;
          default: th = (th + 1) % 10;
        endcase
        m_t = mi * 600 + te * 100 + se * 10 + th;
      end
    end else if (e) begin
      m_encnt++;
      if (m_encnt % TICK_DIV == 0 && m_t != m_goal) begin
        if (m_dir) m_t--; else m_t++;
      end
    end
  endtask

  task automatic cyc(input bit e, input bit d, input bit i, input bit n);
    bus.en = e; bus.dir_pulse = d; bus.inc_pulse = i; bus.enter_pulse = n;
    @(posedge clk); #1;
    model_step(e, d, i, n);
    m_cyc++;
    bus.dir_pulse = 1'b0; bus.inc_pulse = 1'b0; bus.enter_pulse = 1'b0;
  endtask

  task automatic do_reset();
    bus.en = 1'b0; bus.dir_pulse = 1'b0; bus.inc_pulse = 1'b0; bus.enter_pulse = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_state = 0; m_t = 0; m_goal = 0; m_encnt = 0; m_dir = 1'b0; m_cyc = 0;
  endtask

  // From DIR: walk all SET states with the given digit counts, ending in RUN.
  task automatic enter_time(input int mi, input int te, input int se, input int th);
    cyc(0, 0, 0, 1);
    for (int k = 0; k < mi; k++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    for (int k = 0; k < te; k++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    for (int k = 0; k < se; k++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    for (int k = 0; k < th; k++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++; if (bus.DIGIT !== 4'b1110) $display("FAIL reset_digit got=%b exp=1110", bus.DIGIT); else passes++;
    checks++; if (bus.DISPLAY !== DASH) $display("FAIL reset_display got=%b exp=%b", bus.DISPLAY, DASH); else passes++;
    checks++; if (bus.dir_led !== 1'b0) $display("FAIL reset_dir_led got=%b exp=0", bus.dir_led); else passes++;
    checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else passes++;
    checks++; if (bus.time_bcd !== 16'h0000) $display("FAIL reset_time got=%h exp=0000", bus.time_bcd); else passes++;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0, 0);
      checks++; if (bus.DIGIT !== dig_tab[(m_cyc / SCAN_DIV) % 4])
        $display("FAIL dir_scan_digit cyc=%0d got=%b exp=%b", m_cyc, bus.DIGIT, dig_tab[(m_cyc / SCAN_DIV) % 4]); else passes++;
      checks++; if (bus.DISPLAY !== DASH) $display("FAIL dir_dash cyc=%0d got=%b exp=%b", m_cyc, bus.DISPLAY, DASH); else passes++;
    end
    $display("test_reset done: %0d/%0d", passes, checks);
  endtask

  task automatic test_count_up();
    do_reset();
    enter_time(1, 0, 1, 0);
    for (int k = 0; k < 2600; k++) begin
      cyc(1, 0, 0, 0);
      checks++; if (bus.time_bcd !== to_bcd(m_t)) $display("FAIL up_time cyc=%0d got=%h exp=%h", k, bus.time_bcd, to_bcd(m_t)); else passes++;
      checks++; if (bus.done !== m_done()) $display("FAIL up_done cyc=%0d got=%b exp=%b", k, bus.done, m_done()); else passes++;
      if (k == 3) begin
        checks++; if (bus.time_bcd !== 16'h0001) $display("FAIL up_first_tick got=%h exp=0001", bus.time_bcd); else passes++;
      end
    end
    checks++; if (bus.time_bcd !== 16'h1010 || bus.done !== 1'b1)
      $display("FAIL up_final got=%h/%b exp=1010/1", bus.time_bcd, bus.done); else passes++;
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 0, 0);
      checks++; if (bus.DIGIT !== dig_tab[(m_cyc / SCAN_DIV) % 4])
        $display("FAIL run_scan_digit cyc=%0d got=%b exp=%b", m_cyc, bus.DIGIT, dig_tab[(m_cyc / SCAN_DIV) % 4]); else passes++;
      checks++; if (bus.DISPLAY !== seg_tab[digit_at(m_t, (m_cyc / SCAN_DIV) % 4)])
        $display("FAIL run_segments cyc=%0d got=%b exp=%b", m_cyc, bus.DISPLAY, seg_tab[digit_at(m_t, (m_cyc / SCAN_DIV) % 4)]); else passes++;
    end
    $display("test_count_up done: %0d/%0d", passes, checks);
  endtask

  task automatic test_count_down();
    do_reset();
    cyc(0, 1, 0, 0);
    checks++; if (bus.dir_led !== 1'b1) $display("FAIL down_dir_led got=%b exp=1", bus.dir_led); else passes++;
    enter_time(1, 0, 0, 0);
    for (int k = 0; k < 2500; k++) begin
      cyc(1, 0, 0, 0);
      checks++; if (bus.time_bcd !== to_bcd(m_t)) $display("FAIL down_time cyc=%0d got=%h exp=%h", k, bus.time_bcd, to_bcd(m_t)); else passes++;
      checks++; if (bus.done !== m_done()) $display("FAIL down_done cyc=%0d got=%b exp=%b", k, bus.done, m_done()); else passes++;
      if (k == 3) begin
        checks++; if (bus.time_bcd !== 16'h0599) $display("FAIL down_first_tick got=%h exp=0599", bus.time_bcd); else passes++;
      end
    end
    checks++; if (bus.time_bcd !== 16'h0000 || bus.done !== 1'b1)
      $display("FAIL down_final got=%h/%b exp=0000/1", bus.time_bcd, bus.done); else passes++;
    $display("test_count_down done: %0d/%0d", passes, checks);
  endtask

  task automatic test_wrap();
    do_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    checks++; if (bus.time_bcd !== 16'h1000) $display("FAIL wrap_min1 got=%h exp=1000", bus.time_bcd); else passes++;
    cyc(0, 0, 1, 0);
    checks++; if (bus.time_bcd !== 16'h0000) $display("FAIL wrap_min0 got=%h exp=0000", bus.time_bcd); else passes++;
    cyc(0, 0, 0, 1);
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0);
    checks++; if (bus.time_bcd !== 16'h0500) $display("FAIL wrap_ten5 got=%h exp=0500", bus.time_bcd); else passes++;
    cyc(0, 0, 1, 0);
    checks++; if (bus.time_bcd !== 16'h0000) $display("FAIL wrap_ten0 got=%h exp=0000", bus.time_bcd); else passes++;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 1);
    checks++; if (bus.time_bcd !== 16'h0010) $display("FAIL enter_beats_inc got=%h exp=0010", bus.time_bcd); else passes++;
    checks++; if (bus.dir_led !== 1'b0) $display("FAIL set_dir_ignored got=%b exp=0", bus.dir_led); else passes++;
    cyc(0, 0, 1, 0);
    checks++; if (bus.time_bcd !== 16'h0011) $display("FAIL in_set_tenth got=%h exp=0011", bus.time_bcd); else passes++;
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 0);
      checks++; if (bus.DISPLAY !== seg_tab[digit_at(m_t, (m_cyc / SCAN_DIV) % 4)])
        $display("FAIL set_segments cyc=%0d got=%b exp=%b", m_cyc, bus.DISPLAY, seg_tab[digit_at(m_t, (m_cyc / SCAN_DIV) % 4)]); else passes++;
    end
    $display("test_wrap done: %0d/%0d", passes, checks);
  endtask

  task automatic test_zero_target();
    for (int d = 0; d < 2; d++) begin
      do_reset();
      if (d == 1) cyc(0, 1, 0, 0);
      enter_time(0, 0, 0, 0);
      checks++; if (bus.done !== 1'b1) $display("FAIL zero_done_now dir=%0d got=%b exp=1", d, bus.done); else passes++;
      for (int k = 0; k < 12; k++) cyc(1, 0, 0, 0);
      checks++; if (bus.time_bcd !== 16'h0000 || bus.done !== 1'b1)
        $display("FAIL zero_hold dir=%0d got=%h/%b exp=0000/1", d, bus.time_bcd, bus.done); else passes++;
    end
    $display("test_zero_target done: %0d/%0d", passes, checks);
  endtask

  task automatic test_pause();
    do_reset();
    enter_time(1, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(1, 0, 0, 0);
    checks++; if (bus.time_bcd !== 16'h0001) $display("FAIL pause_start got=%h exp=0001", bus.time_bcd); else passes++;
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0, 0);
      checks++; if (bus.time_bcd !== 16'h0001) $display("FAIL pause_frozen cyc=%0d got=%h exp=0001", k, bus.time_bcd); else passes++;
    end
    cyc(1, 0, 0, 0);
    checks++; if (bus.time_bcd !== 16'h0001) $display("FAIL resume_early got=%h exp=0001", bus.time_bcd); else passes++;
    cyc(1, 0, 0, 0);
    checks++; if (bus.time_bcd !== 16'h0002) $display("FAIL resume_phase got=%h exp=0002", bus.time_bcd); else passes++;
    for (int k = 0; k < 200; k++) begin
      cyc(1'($urandom_range(0, 1)), 0, 0, 0);
      checks++; if (bus.time_bcd !== to_bcd(m_t)) $display("FAIL pause_rand cyc=%0d got=%h exp=%h", k, bus.time_bcd, to_bcd(m_t)); else passes++;
    end
    $display("test_pause done: %0d/%0d", passes, checks);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      do_reset();
      if ($urandom_range(0, 1) == 1) cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 1);
      for (int f = 0; f < 4; f++) begin
        int n = $urandom_range(0, 12);
        for (int k = 0; k < n; k++) begin
          cyc(0, 0, 1, 0);
          checks++; if (bus.time_bcd !== to_bcd(m_t)) $display("FAIL rand_set it=%0d got=%h exp=%h", it, bus.time_bcd, to_bcd(m_t)); else passes++;
        end
        cyc(0, 0, 1'($urandom_range(0, 1)), 1);
      end
      for (int k = 0; k < 1200; k++) begin
        cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
        checks++; if (bus.time_bcd !== to_bcd(m_t)) $display("FAIL rand_time it=%0d cyc=%0d got=%h exp=%h", it, k, bus.time_bcd, to_bcd(m_t)); else passes++;
        checks++; if (bus.done !== m_done()) $display("FAIL rand_done it=%0d cyc=%0d got=%b exp=%b", it, k, bus.done, m_done()); else passes++;
        checks++; if (bus.dir_led !== m_dir) $display("FAIL rand_dir it=%0d cyc=%0d got=%b exp=%b", it, k, bus.dir_led, m_dir); else passes++;
      end
    end
    $display("test_random done: %0d/%0d", passes, checks);
  endtask

  task automatic test_reset_mid_run();
    int k = 0;
    do_reset();
    cyc(0, 1, 0, 0);
    enter_time(1, 0, 0, 0);
    while (m_t != 305 && k < 2000) begin
      cyc(1, (k == 50), 0, (k == 60));
      checks++; if (bus.dir_led !== 1'b1) $display("FAIL run_dir_ignored cyc=%0d got=%b exp=1", k, bus.dir_led); else passes++;
      k++;
    end
    checks++; if (bus.time_bcd !== 16'h0305) $display("FAIL reach_0305 got=%h exp=0305", bus.time_bcd); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (bus.time_bcd !== 16'h0000) $display("FAIL async_time got=%h exp=0000", bus.time_bcd); else passes++;
    checks++; if (bus.dir_led !== 1'b0) $display("FAIL async_dir got=%b exp=0", bus.dir_led); else passes++;
    checks++; if (bus.done !== 1'b0) $display("FAIL async_done got=%b exp=0", bus.done); else passes++;
    checks++; if (bus.DISPLAY !== DASH) $display("FAIL async_display got=%b exp=%b", bus.DISPLAY, DASH); else passes++;
    checks++; if (bus.DIGIT !== 4'b1110) $display("FAIL async_digit got=%b exp=1110", bus.DIGIT); else passes++;
    do_reset();
    cyc(0, 1, 0, 0);
    checks++; if (bus.dir_led !== 1'b1) $display("FAIL after_reset_dir got=%b exp=1", bus.dir_led); else passes++;
    $display("test_reset_mid_run done: %0d/%0d", passes, checks);
  endtask

  initial begin
    bus.en = 1'b0; bus.dir_pulse = 1'b0; bus.inc_pulse = 1'b0; bus.enter_pulse = 1'b0;
    m_state = 0; m_t = 0; m_goal = 0; m_encnt = 0; m_dir = 1'b0; m_cyc = 0;
    test_reset();
    test_count_up();
    test_count_down();
    test_wrap();
    test_zero_target();
    test_pause();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
